// File: rtl/pwm_pkg.sv
// Package shared by the PWM capture block and the PWM generator.
// Holds the capture FSM state type and the default counter width / timeout.
package pwm_pkg;

  localparam int unsigned PWM_CNT_W   = 32;
  localparam int unsigned PWM_TIMEOUT = 50_000_000;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEAS_HIGH = 2'd2,
    MEAS_LOW  = 2'd3
  } pwm_cap_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// Capture-side bundle for pwm_capture.
//   cap_en    : capture enable (driven by the master)
//   pwm_in    : asynchronous waveform to be measured (driven by the master)
//   period_o  : last measured period in clk cycles
//   high_o    : last measured high time in clk cycles
//   valid_o   : one-cycle strobe when period_o/high_o update
//   timeout_o : sticky stall flag
// master = the side that drives cap_en/pwm_in; slave = pwm_capture itself.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W = PWM_CNT_W
) ();

  logic             cap_en;
  logic             pwm_in;
  logic [CNT_W-1:0] period_o;
  logic [CNT_W-1:0] high_o;
  logic             valid_o;
  logic             timeout_o;

  modport master (
    output cap_en, pwm_in,
    input  period_o, high_o, valid_o, timeout_o
  );

  modport slave (
    input  cap_en, pwm_in,
    output period_o, high_o, valid_o, timeout_o
  );

endinterface

// File: rtl/pwm_capture_sync_edge.sv
// pwm_sync_edge: brings the asynchronous PWM input into the clk domain and
// produces single-cycle rise/fall strobes.
//   clk, rst : clock and synchronous active-high reset
//   pwm_in   : asynchronous input
//   level    : synchronized (and optionally filtered) level
//   rise     : one-cycle strobe on a 0->1 transition of level
//   fall     : one-cycle strobe on a 1->0 transition of level
// Macro PWM_CAPTURE_GLITCH_FILTER_EN inserts a stability filter after the
// synchronizer: the level only changes once the new value has been seen for
// FILT_LEN consecutive cycles (adds FILT_LEN cycles of latency to each edge).
module pwm_sync_edge
  import pwm_pkg::*;
#(
  parameter int unsigned FILT_LEN = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  if (FILT_LEN == 0) begin : g_filt_len_check
    $error("pwm_sync_edge: FILT_LEN must be at least 1");
  end

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic edge_q,  edge_d;
  logic lvl;

  assign sync1_d = pwm_in;
  assign sync2_d = sync1_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      edge_q  <= edge_d;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  localparam int unsigned FC_W = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic            filt_q, filt_d;
  logic [FC_W-1:0] fcnt_q, fcnt_d;

  // fcnt counts how many consecutive cycles sync2 has disagreed with the
  // filtered level; the level flips on the FILT_LEN-th such cycle.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (sync2_q != filt_q) begin
      if (fcnt_q == FC_W'(FILT_LEN - 1)) begin
        filt_d = sync2_q;
      end else begin
        fcnt_d = fcnt_q + FC_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= 1'b0;
      fcnt_q <= '0;
    end else begin
      filt_q <= filt_d;
      fcnt_q <= fcnt_d;
    end
  end

  assign lvl = filt_q;
`else
  assign lvl = sync2_q;
`endif

  assign edge_d = lvl;
  assign level  = lvl;
  assign rise   = lvl & ~edge_q;
  assign fall   = ~lvl & edge_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input.
//   clk, rst : clock and synchronous active-high reset (reset wins over all)
//   bus      : pwm_capture_if slave -- cap_en/pwm_in in,
//              period_o/high_o/valid_o/timeout_o out
// A measurement runs rise-to-rise: the counter restarts at 1 after every
// rise, the fall snapshots the high time, and the next rise publishes the
// result. A stalled waveform sets the sticky timeout_o flag.
// Macro PWM_CAPTURE_GLITCH_FILTER_EN enables the input glitch filter inside
// pwm_sync_edge; measured values for clean inputs are identical either way.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int unsigned CNT_W    = PWM_CNT_W,
  parameter int unsigned TIMEOUT  = PWM_TIMEOUT,
  parameter int unsigned FILT_LEN = 4
) (
  input  logic            clk,
  input  logic            rst,
  pwm_capture_if.slave    bus
);

  localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT);

  logic level, rise, fall, rise_ev;

  pwm_sync_edge #(
    .FILT_LEN (FILT_LEN)
  ) u_sync_edge (
    .clk    (clk),
    .rst    (rst),
    .pwm_in (bus.pwm_in),
    .level  (level),
    .rise   (rise),
    .fall   (fall)
  );

  // A rise strobe always coincides with level high; qualifying on both keeps
  // the measurement anchored to the same signal the strobe was derived from.
  assign rise_ev = rise & level;

  pwm_cap_state_t   state_q,   state_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic [CNT_W-1:0] hi_q,      hi_d;
  logic [CNT_W-1:0] period_q,  period_d;
  logic [CNT_W-1:0] high_q,    high_d;
  logic             valid_q,   valid_d;
  logic             timeout_q, timeout_d;
  logic             at_limit;

  assign at_limit = (cnt_q == TMO);

  always_comb begin
    state_d   = state_q;
    hi_d      = hi_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    if (state_q == IDLE) begin
      cnt_d = '0;
    end else if (rise_ev) begin
      cnt_d = CNT_W'(1);
    end else if (!at_limit) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      cnt_d = cnt_q;
    end

    if (!bus.cap_en) begin
      state_d   = IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = WAIT_RISE;
        end
        WAIT_RISE: begin
          if (rise_ev) state_d = MEAS_HIGH;
        end
        MEAS_HIGH: begin
          if (fall) begin
            hi_d    = cnt_q;
            state_d = MEAS_LOW;
          end else if (at_limit) begin
            timeout_d = 1'b1;
            state_d   = WAIT_RISE;
          end
        end
        MEAS_LOW: begin
          if (rise_ev) begin
            period_d  = cnt_q;
            high_d    = hi_q;
            valid_d   = 1'b1;
            timeout_d = 1'b0;
            state_d   = MEAS_HIGH;
          end else if (at_limit) begin
            timeout_d = 1'b1;
            state_d   = WAIT_RISE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.period_o  = period_q;
  assign bus.high_o    = high_q;
  assign bus.valid_o   = valid_q;
  assign bus.timeout_o = timeout_q;

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the measurement counter and result outputs.
REQ-002 SHALL have parameter TIMEOUT, default 50_000_000, the cycles without a qualifying edge before a timeout is declared.
REQ-003 SHALL have parameter FILT_LEN, default 4, the glitch-filter stability length in cycles (used only with the filter macro).
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cap_en  input  1  capture enable; low forces IDLE.
REQ-007 SHALL have port pwm_in  input  1  asynchronous PWM waveform to be measured.
REQ-008 SHALL have port period_o  output  CNT_W  last measured period, in clk cycles.
REQ-009 SHALL have port high_o  output  CNT_W  last measured high time, in clk cycles.
REQ-010 SHALL have port valid_o  output  1  one-cycle pulse when period_o and high_o update.
REQ-011 SHALL have port timeout_o  output  1  sticky flag: the waveform stalled (0% or 100% duty, or no input).

Function
REQ-012 SHALL pass pwm_in through a 2-flop synchronizer, then register it once more for edge detection; rise/fall pulses appear 3 cycles after the input edge.
REQ-013 SHALL implement FSM states IDLE, WAIT_RISE, MEAS_HIGH and MEAS_LOW.
REQ-014 Transitions SHALL be:
- IDLE->WAIT_RISE when cap_en=1.
- WAIT_RISE->MEAS_HIGH on rise.
- MEAS_HIGH->MEAS_LOW on fall.
- MEAS_LOW->MEAS_HIGH on rise.
- any state->IDLE when cap_en=0.
REQ-015 The counter SHALL load 1 in the cycle after a rise pulse and increment by 1 every cycle otherwise, saturating at TIMEOUT.
REQ-016 On a fall in MEAS_HIGH, the block SHALL capture the counter value into an internal high register, so a clean H-cycle high phase yields H.
REQ-017 On a rise in MEAS_LOW, the block SHALL load period_o with the counter value, load high_o from the internal high register, and pulse valid_o for 1 cycle, all in the cycle after the rise pulse.
REQ-018 The first rise after WAIT_RISE SHALL NOT produce valid_o; the first valid_o occurs on the second rise.
REQ-019 When the counter reaches TIMEOUT in MEAS_HIGH or MEAS_LOW, the block SHALL set timeout_o and go to WAIT_RISE; period_o and high_o hold.
REQ-020 timeout_o SHALL clear on the next valid_o, on cap_en=0, or on rst.
REQ-021 When cap_en falls mid-measurement, the block SHALL abort with no valid_o; period_o and high_o hold their last values.
REQ-022 period_o and high_o SHALL change only when valid_o is high.
REQ-023 Results SHALL be unsigned, and high_o < period_o SHALL hold for every valid result.

Reset
REQ-024 On rst=1 at a clk edge, the state SHALL be IDLE, the counter 0, period_o 0, high_o 0, valid_o 0 and timeout_o 0.
REQ-025 On rst=1 at a clk edge, synchronizer and filter flops SHALL be cleared to 0.
REQ-026 rst SHALL take priority over cap_en and all edges, including mid-measurement.

Configuration
REQ-027 With PWM_CAPTURE_GLITCH_FILTER_EN defined, the synchronized input SHALL change only after being stable for FILT_LEN consecutive cycles, which adds FILT_LEN cycles of edge latency.
REQ-028 Under the same macro, pulses shorter than FILT_LEN cycles SHALL be ignored.
REQ-029 Without PWM_CAPTURE_GLITCH_FILTER_EN, the filter SHALL be absent and edge latency SHALL be exactly 3 cycles.
REQ-030 Measured period_o and high_o values SHALL be identical in both builds for clean inputs.

Structure
REQ-031 Shared package pwm_pkg SHALL hold the FSM state typedef (pwm_cap_state_t) and default CNT_W/TIMEOUT constants shared with the PWM generator.
REQ-032 Synchronizer, optional filter and edge detection SHALL live in sub-module pwm_sync_edge (outputs level, rise, fall).
REQ-033 The FSM and counter SHALL live in pwm_capture.

Verification
REQ-034 Clean PWM with period 100 and high 30, cap_en=1 -> first valid_o on the second rise with period_o=100 and high_o=30, then repeating every 100 cycles.
REQ-035 Constant low after one rise, TIMEOUT=1000 -> timeout_o=1 exactly 1000 cycles after the counter load, state WAIT_RISE; the next full period clears it with valid_o.
REQ-036 Period changes from 100/30 to 50/10 -> the next valid_o reports 100/30 (boundary period), then 50/10.
REQ-037 cap_en dropped in MEAS_HIGH, then reasserted -> no valid_o, outputs hold; a new measurement needs two rises.
REQ-038 rst pulsed mid-measurement (high 1 cycle) -> all outputs 0 next cycle and state IDLE.
REQ-039 2-cycle high glitch inside a low phase, FILT_LEN=4 -> with macro: ignored, period unchanged; without macro: measured as a rise, reported high_o=2.
